// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
package fifo_pkg;

    localparam int   DEF_WIDTH     = 8;
    localparam int   DEF_DEPTH     = 16;
    localparam logic DATAO_RST_BIT = 1'b0;

    // Occupancy and pointers carry one extra lap bit so 0..DEPTH is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write, address-selected read word.
// The output register that holds read data lives in fifo_param so it can be reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with exact occupancy count and threshold flags.
// Sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          wr,
    input  logic [WIDTH-1:0]              datain,
    input  logic                          rd,
    output logic [WIDTH-1:0]              datao,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    input  logic                          err_clr,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] datao_q, datao_d;
    logic [WIDTH-1:0] rd_data;
    logic             wr_acc;
    logic             rd_acc;

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign datao        = datao_q;

    always_comb begin
        wr_acc   = wr & ~full;
        rd_acc   = rd & ~empty;
        wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
        // Modulo subtraction across the lap bit gives occupancy directly.
        count_d  = wr_ptr_d - rd_ptr_d;
        datao_d  = rd_acc ? rd_data : datao_q;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            datao_q  <= {WIDTH{DATAO_RST_BIT}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            datao_q  <= datao_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (datain),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A new error in the clearing cycle takes priority over err_clr.
    always_comb begin
        ovf_d = ovf_q & ~err_clr;
        unf_d = unf_q & ~err_clr;
        if (wr && full) begin
            ovf_d = 1'b1;
        end
        if (rd && empty) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: queue-based reference model feeds expected
// per-cycle state to a monitor; a second DEPTH=8 instance exercises thresholds.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       res;
    logic       wr, rd, err_clr;
    logic [7:0] datain, datao;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       res8, wr8, rd8, clr8;
    logic [7:0] din8, dout8;
    logic       full8, empty8, af8, ae8, ovf8, unf8;
    logic [3:0] count8;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         cnt;
        logic [7:0] datao;
        bit         ovf;
        bit         unf;
    } st_t;

    st_t        st_q[$];
    logic [7:0] m_q[$];
    logic [7:0] m_datao;
    bit         m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk), .res(res), .wr(wr), .datain(datain), .rd(rd), .datao(datao),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut8 (
        .clk(clk), .res(res8), .wr(wr8), .datain(din8), .rd(rd8), .datao(dout8),
        .full(full8), .empty(empty8), .almost_full(af8),
        .almost_empty(ae8), .count(count8), .err_clr(clr8),
        .overflow(ovf8), .underflow(unf8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from the pre-edge occupancy.
    task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit clr);
        int  n;
        st_t e;
        @(negedge clk);
        wr = w; datain = d; rd = r; err_clr = clr;
        n = m_q.size();
        if (r && n > 0) m_datao = m_q.pop_front();
        if (w && n < 16) m_q.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (w && n == 16) m_ovf = 1;
        if (r && n == 0) m_unf = 1;
`endif
        e.cnt = m_q.size(); e.datao = m_datao; e.ovf = m_ovf; e.unf = m_unf;
        st_q.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 8'h00, 0, 0);
    endtask

    always @(posedge clk) begin
        st_t e;
        #2;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("full", 32'(full), 32'(e.cnt == 16));
            chk("empty", 32'(empty), 32'(e.cnt == 0));
            chk("almost_full", 32'(almost_full), 32'(e.cnt >= 14));
            chk("almost_empty", 32'(almost_empty), 32'(e.cnt <= 2));
            chk("datao", 32'(datao), 32'(e.datao));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
        end
    end

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_ae"}, 32'(almost_empty), 1);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_datao"}, 32'(datao), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        res = 0; wr = 0; rd = 0; err_clr = 0; datain = 0;
        res8 = 0; wr8 = 0; rd8 = 0; clr8 = 0; din8 = 0;
        m_datao = 0; m_ovf = 0; m_unf = 0;
        repeat (2) @(negedge clk);
        chk_reset_state("por");
        res = 1; res8 = 1;

        // Mid-stream reset with five words held and a non-zero datao.
        for (int i = 0; i < 6; i++) cyc(1, 8'h51 + 8'(i), 0, 0);
        cyc(0, 8'h00, 1, 0);
        idle();
        @(negedge clk);
        res = 0;
        #1;
        chk_reset_state("async_rst");
        m_q.delete(); m_datao = 0; m_ovf = 0; m_unf = 0;
        @(negedge clk);
        res = 1;
        cyc(1, 8'hA5, 0, 0);
        cyc(0, 8'h00, 1, 0);
        idle();

        // Fill, overflow attempt, drain, underflow attempt, clear.
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 0);
        idle(); idle();
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        idle();
        cyc(0, 8'h00, 0, 1);
        idle();

        // Wrap-around rounds.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 10; i++) cyc(1, 8'($urandom), 0, 0);
            for (int i = 0; i < 10; i++) cyc(0, 8'h00, 1, 0);
        end

        // Simultaneous access at count 7, 0 and 16.
        for (int i = 0; i < 7; i++) cyc(1, 8'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h3C, 1, 0);
        cyc(0, 8'h00, 1, 0);
        for (int i = 0; i < 16; i++) cyc(1, 8'($urandom), 0, 0);
        cyc(1, 8'hDD, 1, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 0, 1);

        // Randomised traffic: a filling phase then a draining phase.
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 40,
                $urandom_range(0, 15) == 0);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 99) < 70,
                $urandom_range(0, 15) == 0);
        idle(); idle();

        // Threshold instance: DEPTH=8, AF_LEVEL=6, AE_LEVEL=1.
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); wr8 = 1; din8 = 8'h30 + 8'(i);
            @(negedge clk); wr8 = 0;
            chk("d8_count_w", 32'(count8), 32'(i));
            chk("d8_af_w", 32'(af8), 32'(i >= 6));
            chk("d8_ae_w", 32'(ae8), 32'(i <= 1));
            chk("d8_full_w", 32'(full8), 32'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); rd8 = 1;
            @(negedge clk); rd8 = 0;
            chk("d8_count_r", 32'(count8), 32'(8 - i));
            chk("d8_data_r", 32'(dout8), 32'(8'h30 + 8'(i)));
            chk("d8_af_r", 32'(af8), 32'((8 - i) >= 6));
            chk("d8_ae_r", 32'(ae8), 32'((8 - i) <= 1));
            chk("d8_empty_r", 32'(empty8), 32'(i == 8));
        end

        repeat (3) @(negedge clk);
        if (st_q.size() != 0) chk("scoreboard_drained", 32'(st_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
